cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/core_pkg.sv | 18 +
 rtl/cdb_arbiter_if.sv | 41 ++++
 rtl/rr_multi_picker.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions.
// Holds the default datapath widths and the CDB lane record used by both the
// CDB arbiter and the reservation stations that snoop the broadcast bus.
package core_pkg;

  localparam int unsigned CORE_PHYS_W = 6;
  localparam int unsigned CORE_XLEN   = 64;
  localparam int unsigned CORE_ROB_W  = 6;

  // One broadcast lane as seen by a consumer snooping the CDB.
  typedef struct packed {
    logic                   valid;
    logic [CORE_PHYS_W-1:0] tag;
    logic [CORE_XLEN-1:0]   value;
    logic [CORE_ROB_W-1:0]  rob_tag;
  } cdb_lane_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester / CDB bundle between functional units and the CDB arbiter.
// master: functional-unit side (drives req_*, observes req_ready and cdb_*).
// slave : arbiter side (consumes req_*, drives req_ready and cdb_*).
//   req_valid   [N_REQ]          result pending
//   req_tag     [N_REQ][PHYS_W]  destination physical tag
//   req_value   [N_REQ][XLEN]    result value
//   req_rob_tag [N_REQ][ROB_W]   ROB entry
//   req_ready   [N_REQ]          combinational grant
//   cdb_*       [CDB_W]          registered broadcast lanes
interface cdb_arbiter_if
  import core_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CDB_W  = 2,
  parameter int unsigned PHYS_W = CORE_PHYS_W,
  parameter int unsigned XLEN   = CORE_XLEN,
  parameter int unsigned ROB_W  = CORE_ROB_W
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][PHYS_W-1:0] req_tag;
  logic [N_REQ-1:0][XLEN-1:0]   req_value;
  logic [N_REQ-1:0][ROB_W-1:0]  req_rob_tag;
  logic [N_REQ-1:0]             req_ready;

  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0] cdb_tag;
  logic [CDB_W-1:0][XLEN-1:0]   cdb_value;
  logic [CDB_W-1:0][ROB_W-1:0]  cdb_rob_tag;

  modport master (
    output req_valid, req_tag, req_value, req_rob_tag,
    input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

  modport slave (
    input  req_valid, req_tag, req_value, req_rob_tag,
    output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

endinterface

// File: rtl/rr_multi_picker.sv
// Combinational round-robin picker granting up to CDB_W requesters per cycle.
// Scans req starting at start with modular wrap; the k-th hit goes to lane k.
//   req        in  [N_REQ]         candidate requests
//   start      in  [PTR_W]         first index to scan
//   grant      out [CDB_W][N_REQ]  per-lane one-hot grant
//   lane_valid out [CDB_W]         lane carries a grant
//   lane_idx   out [CDB_W][PTR_W]  requester index per lane
//   last_idx   out [PTR_W]         index of the last granted requester
//   any        out 1               at least one grant
module rr_multi_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CDB_W = 2,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [PTR_W-1:0]            start,
  output logic [CDB_W-1:0][N_REQ-1:0] grant,
  output logic [CDB_W-1:0]            lane_valid,
  output logic [CDB_W-1:0][PTR_W-1:0] lane_idx,
  output logic [PTR_W-1:0]            last_idx,
  output logic                        any
);

  localparam logic [PTR_W:0] NReqW = (PTR_W + 1)'(N_REQ);

  logic [N_REQ-1:0] remaining;
  logic [N_REQ-1:0] rot;
  logic             found;
  logic [PTR_W-1:0] pos;
  logic [PTR_W:0]   sum;

  always_comb begin
    remaining  = req;
    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    last_idx   = start;
    rot        = '0;
    found      = 1'b0;
    pos        = '0;
    sum        = '0;
    for (int l = 0; l < int'(CDB_W); l++) begin
      // Rotate so bit 0 is the start position, then take the first set bit.
      rot   = N_REQ'({remaining, remaining} >> start);
      found = 1'b0;
      pos   = '0;
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (!found && rot[j]) begin
          found = 1'b1;
          pos   = PTR_W'(j);
        end
      end
      if (found) begin
        sum = {1'b0, start} + {1'b0, pos};
        if (sum >= NReqW) begin
          sum = sum - NReqW;
        end
        lane_valid[l]                  = 1'b1;
        lane_idx[l]                    = sum[PTR_W-1:0];
        grant[l][sum[PTR_W-1:0]]       = 1'b1;
        remaining[sum[PTR_W-1:0]]      = 1'b0;
        last_idx                       = sum[PTR_W-1:0];
      end
    end
    any = |lane_valid;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to CDB_W completed results per cycle in
// round-robin order and broadcasts them on registered CDB lanes.
//   clk       in  1   rising-edge clock
//   reset     in  1   asynchronous active-high reset
//   flush     in  1   pipeline flush: no grants, no broadcast next cycle
//   bus       slave   requester handshake and CDB lanes (cdb_arbiter_if)
//   stall_cnt out 16  saturating count of cycles with an ungranted requester
module cdb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CDB_W  = 2,
  parameter int unsigned PHYS_W = CORE_PHYS_W,
  parameter int unsigned XLEN   = CORE_XLEN,
  parameter int unsigned ROB_W  = CORE_ROB_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]             cand;
  logic [N_REQ-1:0]             ready;
  logic [CDB_W-1:0][N_REQ-1:0]  grant;
  logic [CDB_W-1:0]             lane_valid;
  logic [CDB_W-1:0][PTR_W-1:0]  lane_idx;
  logic [PTR_W-1:0]             last_idx;
  logic                         any_grant;
  logic                         stall_event;

  logic [CDB_W-1:0]             cdb_valid_q;
  logic [CDB_W-1:0][PHYS_W-1:0] cdb_tag_q;
  logic [CDB_W-1:0][XLEN-1:0]   cdb_value_q;
  logic [CDB_W-1:0][ROB_W-1:0]  cdb_rob_tag_q;
  logic [15:0]                  stall_q;

  // Grants are suppressed during reset and flush; payload never enters here.
  assign cand = (reset || flush) ? '0 : bus.req_valid;

  rr_multi_picker #(
    .N_REQ (N_REQ),
    .CDB_W (CDB_W)
  ) u_picker (
    .req        (cand),
    .start      (rr_ptr_q),
    .grant      (grant),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .last_idx   (last_idx),
    .any        (any_grant)
  );

  always_comb begin
    ready = '0;
    for (int l = 0; l < int'(CDB_W); l++) begin
      ready = ready | grant[l];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  assign stall_event = !flush && |(bus.req_valid & ~ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid_q   <= '0;
      cdb_tag_q     <= '0;
      cdb_value_q   <= '0;
      cdb_rob_tag_q <= '0;
      rr_ptr_q      <= '0;
      stall_q       <= '0;
    end else begin
      cdb_valid_q <= lane_valid;
      for (int l = 0; l < int'(CDB_W); l++) begin
        // Idle lanes keep their last payload; only valid drops.
        if (lane_valid[l]) begin
          cdb_tag_q[l]     <= bus.req_tag[lane_idx[l]];
          cdb_value_q[l]   <= bus.req_value[lane_idx[l]];
          cdb_rob_tag_q[l] <= bus.req_rob_tag[lane_idx[l]];
        end
      end
      rr_ptr_q <= rr_ptr_d;
      if (stall_event && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_tag     = cdb_tag_q;
  assign bus.cdb_value   = cdb_value_q;
  assign bus.cdb_rob_tag = cdb_rob_tag_q;
  assign stall_cnt       = stall_q;

endmodule
